// File: rtl/booth_product_accumulator_pkg.sv
// booth_pkg: shared types and defaults for the Booth product accumulator.
//   state_t      : window FSM state {IDLE, ACCUM, DONE}
//   *_W_DEF      : default widths for product, accumulator and length config
//   sign_extend  : sign-extends the low src_w bits of a 64-bit value
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int LEN_W_DEF  = 8;

  // Callers pass a zero-extended value and cast the 64-bit result down to
  // their own width, so one function serves any PROD_W/ACC_W pair <= 64.
  function automatic logic [63:0] sign_extend(input logic [63:0] v, input int src_w);
    logic [63:0] mask;
    logic        msb;
    mask = {64{1'b1}} << src_w;
    msb  = v[6'(src_w - 1)];
    return msb ? (v | mask) : (v & ~mask);
  endfunction

endpackage

// File: rtl/booth_product_accumulator_if.sv
// booth_product_accumulator_if: product input and window-result output
// channels of the accumulator.
//   in_valid/in_ready/in_prod            : product stream into the block
//   out_valid/out_ready/out_acc/out_ovf  : window result out of the block
//   master : the environment side (upstream producer + downstream consumer)
//   slave  : the accumulator side
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both high. A source holding valid must keep its payload stable until the
// transfer; ready may be driven independently of valid.
interface booth_product_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/booth_product_accumulator_adder.sv
// booth_acc_adder: combinational accumulate step.
//   acc      in  ACC_W   current accumulator value (signed)
//   prod     in  PROD_W  signed product
//   next_acc out ACC_W   acc + sext(prod), wrapped or clamped
//   ovf      out 1       signed overflow on this add
// Build option BOOTH_ACC_SAT_EN: when defined, an overflowing sum clamps to
// the most positive / most negative value matching the operands' sign;
// otherwise it wraps in two's complement.
module booth_acc_adder
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  next_acc,
  output logic              ovf
);

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;

  always_comb begin
    prod_ext = ACC_W'(sign_extend(64'(prod), PROD_W));
    sum      = acc + prod_ext;
    // Same-sign operands producing a different-sign sum.
    add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

`ifdef BOOTH_ACC_SAT_EN
  always_comb begin
    next_acc = sum;
    if (add_ovf) begin
      next_acc = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign next_acc = sum;
`endif

  assign ovf = add_ovf;

endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums a programmable window of signed products
// from the Booth multiplier and presents the window total downstream.
//   clk, rst   : clock, synchronous active-high reset
//   cfg_len    : products per window (0 means 2^LEN_W), sampled while IDLE
//   bus        : slave side of booth_product_accumulator_if
//   busy       : a window is in progress or its result is unconsumed
//   dbg_state  : current FSM state, for observation
// Build option BOOTH_ACC_SAT_EN selects saturating instead of wrapping sums
// (see booth_acc_adder); ports are the same either way.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LEN_W-1:0]       cfg_len,
  booth_product_accumulator_if.slave bus,
  output logic                   busy,
  output state_t                 dbg_state
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [LEN_W:0]   count;
  logic [LEN_W:0]   len_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic             out_ovf_q;

  logic [LEN_W:0]   len_eff;
  logic [LEN_W:0]   count_inc;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             ovf_next;
  logic             in_xfer;
  logic             out_xfer;

  always_comb begin
    len_eff   = (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};
    count_inc = count + 1'b1;
    // The first product of a window starts from zero rather than acc.
    acc_base  = (state == IDLE) ? '0 : acc;
    ovf_next  = ((state == IDLE) ? 1'b0 : ovf) | add_ovf;
    in_xfer   = bus.in_valid & in_ready_q;
    out_xfer  = out_valid_q & bus.out_ready;
  end

  booth_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc      (acc_base),
    .prod     (bus.in_prod),
    .next_acc (sum),
    .ovf      (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      ovf         <= 1'b0;
      count       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          len_q <= len_eff;
          if (in_xfer) begin
            acc   <= sum;
            ovf   <= ovf_next;
            count <= {{LEN_W{1'b0}}, 1'b1};
            if (len_eff == {{LEN_W{1'b0}}, 1'b1}) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_acc_q   <= sum;
              out_ovf_q   <= ovf_next;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            acc   <= sum;
            ovf   <= ovf_next;
            count <= count_inc;
            if (count_inc == len_q) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_acc_q   <= sum;
              out_ovf_q   <= ovf_next;
            end
          end
        end
        DONE: begin
          if (out_xfer) begin
            state       <= IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_acc_q   <= '0;
          out_ovf_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator with ACC_W=18 so overflow is reachable
// with a short window. A negedge monitor feeds observed product transfers
// into a window-sum model and checks every result transfer against it.
module tb_booth_product_accumulator;
  import booth_pkg::*;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 18;
  localparam int LEN_W  = 8;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W - 1));
  localparam longint ACC_MOD = 64'sd1 <<< ACC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  state_t           dbg_state;

  booth_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W)) bus ();

  booth_product_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  bit rand_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [ACC_W:0] exp_q[$];   // {ovf, acc}
  int  win_prod[$];
  int  win_len = 0;
  bit  pend = 0;
  int  results = 0;
  int  windows = 0;

  function automatic logic [ACC_W:0] window_result(input int prods[$]);
    longint s = 0;
    bit o = 0;
    logic [63:0] u;
    foreach (prods[i]) begin
      s = s + prods[i];
      if (s > ACC_MAX || s < ACC_MIN) begin
        o = 1;
`ifdef BOOTH_ACC_SAT_EN
        s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
        s = (s > ACC_MAX) ? s - ACC_MOD : s + ACC_MOD;
`endif
      end
    end
    u = 64'(s);
    return {o, u[ACC_W-1:0]};
  endfunction

  always @(negedge clk) begin
    logic [ACC_W:0] e;
    if (rst) begin
      win_prod.delete();
      exp_q.delete();
      pend = 0;
    end else begin
      if (pend) begin
        check("valid_rise", 32'(bus.out_valid), 32'd1);
        check("ready_low_in_done", 32'(bus.in_ready), 32'd0);
        pend = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_acc", 32'(bus.out_acc), 32'(e[ACC_W-1:0]));
          check("sb_ovf", 32'(bus.out_ovf), 32'(e[ACC_W]));
          results++;
        end
      end
      if (!bus.out_valid) begin
        check("acc_zero_idle", 32'(bus.out_acc), 32'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        if (win_prod.size() == 0) win_len = (cfg_len == 0) ? 256 : int'(cfg_len);
        win_prod.push_back(int'($signed(bus.in_prod)));
        if (win_prod.size() == win_len) begin
          exp_q.push_back(window_result(win_prod));
          windows++;
          win_prod.delete();
          pend = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p[PROD_W-1:0];
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      if (rand_mode && n >= 4) bus.out_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(n), 32'd0);
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    repeat (2) cycle();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b1;
    cfg_len       = 8'd4;
    repeat (2) cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_acc", 32'(bus.out_acc), 32'd0);
    check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    cycle();

    // Basic window
    cfg_len = 8'd4;
    send(225); send(0); send(2); send(3);
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    check("basic_acc", 32'(bus.out_acc), 32'd230);
    check("basic_ovf", 32'(bus.out_ovf), 32'd0);
    cycle();
    check("basic_idle", 32'(dbg_state), 32'(IDLE));
    check("basic_busy", 32'(busy), 32'd0);
    settle();

    // Negative window
    cfg_len = 8'd3;
    send(-6); send(-6); send(-12);
    check("neg_acc", 32'(bus.out_acc), 32'h3FFE8);
    check("neg_ovf", 32'(bus.out_ovf), 32'd0);
    settle();

    // Backpressure with a held product
    cfg_len = 8'd2;
    bus.out_ready = 1'b0;
    send(5); send(7);
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'd100;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_acc", 32'(bus.out_acc), 32'd12);
    end
    cycle();
    bus.out_ready = 1'b1;
    send(100); send(1);
    check("bp_next_acc", 32'(bus.out_acc), 32'd101);
    settle();

    // Overflow
    cfg_len = 8'd5;
    repeat (5) send(32767);
`ifdef BOOTH_ACC_SAT_EN
    check("ovf_acc", 32'(bus.out_acc), 32'h1FFFF);
`else
    check("ovf_acc", 32'(bus.out_acc), 32'h27FFB);
`endif
    check("ovf_flag", 32'(bus.out_ovf), 32'd1);
    settle();
    cfg_len = 8'd1;
    send(1);
    check("ovf_cleared", 32'(bus.out_ovf), 32'd0);
    settle();

    // Reset mid-window
    cfg_len = 8'd4;
    send(1); send(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    repeat (4) send(1);
    check("mrst_acc", 32'(bus.out_acc), 32'd4);
    settle();

    // Length one, back to back
    cfg_len = 8'd1;
    send(15);
    check("len1_acc_a", 32'(bus.out_acc), 32'd15);
    check("len1_ready_low", 32'(bus.in_ready), 32'd0);
    c0 = cyc;
    send(-3);
    check("len1_acc_b", 32'(bus.out_acc), 32'h3FFFD);
    check("len1_period", 32'(cyc - c0), 32'd2);
    settle();

    // Length zero means 256
    cfg_len = 8'd0;
    repeat (256) send(1);
    check("len0_acc", 32'(bus.out_acc), 32'd256);
    settle();

    // Randomized windows
    rand_mode = 1;
    repeat (40) begin
      cfg_len = 8'($urandom_range(1, 8));
      n = (cfg_len == 0) ? 256 : int'(cfg_len);
      repeat (n) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        repeat ($urandom_range(0, 2)) cycle();
        send(int'($urandom_range(0, 65535)) - 32768);
      end
      repeat ($urandom_range(0, 3)) cycle();
      bus.out_ready = 1'b1;
    end
    rand_mode = 0;

    // Drain
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(results), 32'(windows));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
- Downstream stage of the combinational 8x8 signed Booth multiplier. Consumes its 16-bit signed product Z.
- Accumulates a programmable-length window of products into a wider signed accumulator, then presents the window sum to the next consumer.
- Valid/ready handshake on both sides; forms the accumulate half of a MAC / dot-product datapath.

Parameters:
- PROD_W, 16, product width; matches the multiplier output Z.
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- LEN_W, 8, width of the window-length configuration.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_len  in  LEN_W  products per window; value 0 means 2^LEN_W.
- in_valid  in  1  in_prod is valid.
- in_ready  out  1  block can accept a product this cycle.
- in_prod  in  PROD_W  signed product from the multiplier.
- out_valid  out  1  out_acc/out_ovf hold a completed window.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_W  signed window sum.
- out_ovf  out  1  sticky flag: signed overflow occurred during the window.
- busy  out  1  a window is in progress (state != IDLE).

Behaviour:
- Reset (one clk with rst=1):
  - state=IDLE, acc=0, count=0, ovf=0.
  - out_valid=0, out_acc=0, out_ovf=0, in_ready=1, busy=0.
  - Reset mid-window or mid-hold discards all partial or unconsumed results.
- A product transfers when in_valid & in_ready. A result transfers when out_valid & out_ready.
- Arithmetic:
  - in_prod is sign-extended to ACC_W, then added to acc in two's complement.
  - Overflow = both operands have the same sign and the sum has a different sign. On overflow, ovf is set sticky for the window.
- IDLE:
  - in_ready=1. len_q is loaded from cfg_len every cycle (0 maps to 2^LEN_W). count is LEN_W+1 bits.
  - On transfer: acc=sext(in_prod), count=1. If len_q==1, go to DONE; else go to ACCUM.
- ACCUM:
  - in_ready=1. cfg_len is ignored; the window length is frozen.
  - On transfer: acc+=prod and count++. If count+1==len_q, go to DONE.
  - No transfer: hold state and acc.
- DONE:
  - in_ready=0, out_valid=1. out_acc and out_ovf are stable until the result transfers.
  - On out_ready: acc=0, ovf=0, count=0, go to IDLE.
- Timing:
  - out_valid rises the cycle after the last product transfer.
  - Minimum window period is len+1 cycles. With len=1, steady throughput is one result per 2 cycles.
- in_valid asserted during DONE: the product is not taken. Upstream must hold it.
- out_acc is registered and equals acc; out_acc reads 0 outside DONE.

Optional Feature:
- Macro: BOOTH_ACC_SAT_EN.
- Defined: on overflow, the sum clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), matching the sign of the operands. Later adds continue from the clamped value. out_ovf is still set.
- Undefined: the sum wraps in two's complement; out_ovf is still set.
- Port list is identical in both builds.

Decomposition:
- Package booth_pkg:
  - State enum {IDLE, ACCUM, DONE}.
  - Default widths: PROD_W=16, ACC_W=24, LEN_W=8.
  - A function for sign extension.
- One sub-module, booth_acc_adder (combinational): inputs acc and prod; outputs next_acc and ovf. Holds the sign extension, the overflow detection and the BOOTH_ACC_SAT_EN clamp.
- The FSM, counter and handshake stay in the top.

Test Plan:
- Basic window: cfg_len=4, products 225, 0, 2, 3, out_ready=1 -> one cycle after the 4th transfer, out_valid=1, out_acc=230, out_ovf=0; next cycle state=IDLE.
- Negative window: cfg_len=3, products -6, -6, -12 -> out_acc=24'hFFFFE8 (-24), out_ovf=0.
- Backpressure: window done, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_acc stable throughout; after out_ready=1 the held product starts the next window and no product is lost.
- Overflow (ACC_W=18): cfg_len=5, in_prod=32767 each.
  - Without BOOTH_ACC_SAT_EN: out_acc=-98309, out_ovf=1.
  - With BOOTH_ACC_SAT_EN: out_acc=131071, out_ovf=1.
- Reset mid-window: cfg_len=4, 2 products accepted, then rst=1 for 1 cycle -> out_valid=0, busy=0, in_ready=1; a new window of 1, 1, 1, 1 gives out_acc=4.
- Length edge cases:
  - cfg_len=1, back-to-back products 15, -3 -> results 15 then -3, one every 2 cycles.
  - cfg_len=0 -> 256 products of 1 give out_acc=256.
